// File: rtl/led_scan_if.sv
// Read port of the 64x4b LED RAM as seen by the matrix scanner.
// The scanner is the master; the RAM returns rd_data one clk after the one-hot address.
interface led_scan_if;
    logic [7:0] rd_row;
    logic [7:0] rd_col;
    logic [3:0] rd_data;

    modport master (
        output rd_row,
        output rd_col,
        input  rd_data
    );

    modport slave (
        input  rd_row,
        input  rd_col,
        output rd_data
    );
endinterface

// File: rtl/led_scan.sv
// 8x8 LED matrix scanner: per row, blank, fetch 8 nibbles from the LED RAM into a
// line buffer, then drive the row with 15-slot PWM per column.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | scan disabled, matrix dark, row_idx held at 0
// BLANK   | all-off gap of BLANK_CYCLES clks between rows
// FETCH   | 9 clks: issue 8 one-hot reads, capture each nibble one clk later
// DISPLAY | 15 PWM slots of SLOT_CYCLES clks on row row_idx
module led_scan #(
    parameter int SLOT_CYCLES  = 64,
    parameter int BLANK_CYCLES = 32,
    parameter int ROW_ACT_LOW  = 0,
    parameter int COL_ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    led_scan_if.master ram,
    output logic [7:0] row_out,
    output logic [7:0] col_out,
    output logic [2:0] row_idx,
    output logic       frame_done
);

    localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SLOT_LOAD  = TW'(SLOT_CYCLES - 1);
    localparam logic [7:0]    ROW_OFF    = (ROW_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0]    COL_OFF    = (COL_ACT_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        FETCH,
        DISPLAY
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [3:0]      k, k_nxt;
    logic [3:0]      slot, slot_nxt;
    logic [2:0]      row_idx_nxt;
    logic [7:0][3:0] line, line_nxt;
    logic            frame_done_nxt;
    logic [7:0]      rd_row_q, rd_col_q, rd_row_nxt, rd_col_nxt;
    logic [7:0]      row_out_nxt, col_out_nxt;
    logic [7:0]      row_act, col_act;

    assign ram.rd_row = rd_row_q;
    assign ram.rd_col = rd_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            k          <= '0;
            slot       <= '0;
            row_idx    <= '0;
            line       <= '0;
            frame_done <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            row_out    <= ROW_OFF;
            col_out    <= COL_OFF;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            k          <= k_nxt;
            slot       <= slot_nxt;
            row_idx    <= row_idx_nxt;
            line       <= line_nxt;
            frame_done <= frame_done_nxt;
            rd_row_q   <= rd_row_nxt;
            rd_col_q   <= rd_col_nxt;
            row_out    <= row_out_nxt;
            col_out    <= col_out_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tmr_nxt        = tmr;
        k_nxt          = k;
        slot_nxt       = slot;
        row_idx_nxt    = row_idx;
        line_nxt       = line;
        frame_done_nxt = 1'b0;

        if (!enable) begin
            state_nxt   = IDLE;
            tmr_nxt     = '0;
            k_nxt       = '0;
            slot_nxt    = '0;
            row_idx_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt   = BLANK;
                    tmr_nxt     = BLANK_LOAD;
                    row_idx_nxt = '0;
                end
                BLANK: begin
                    if (tmr == '0) begin
                        state_nxt = FETCH;
                        k_nxt     = '0;
                    end else begin
                        tmr_nxt = tmr - 1'b1;
                    end
                end
                FETCH: begin
                    // data for the read issued at k-1 is on the bus now
                    if (k != 4'd0) begin
                        line_nxt[3'(k - 4'd1)] = ram.rd_data;
                    end
                    if (k == 4'd8) begin
                        state_nxt = DISPLAY;
                        slot_nxt  = '0;
                        tmr_nxt   = SLOT_LOAD;
                    end else begin
                        k_nxt = k + 4'd1;
                    end
                end
                DISPLAY: begin
                    if (tmr != '0) begin
                        tmr_nxt = tmr - 1'b1;
                    end else if (slot != 4'd14) begin
                        slot_nxt = slot + 4'd1;
                        tmr_nxt  = SLOT_LOAD;
                    end else begin
                        state_nxt      = BLANK;
                        tmr_nxt        = BLANK_LOAD;
                        slot_nxt       = '0;
                        row_idx_nxt    = row_idx + 3'd1;
                        frame_done_nxt = (row_idx == 3'd7);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Pins are registered from the next-state view so they line up with the state they belong to.
    always_comb begin
        rd_row_nxt = '0;
        rd_col_nxt = '0;
        row_act    = '0;
        col_act    = '0;

        if (state_nxt == FETCH && k_nxt != 4'd8) begin
            rd_row_nxt = 8'd1 << row_idx_nxt;
            rd_col_nxt = 8'd1 << k_nxt[2:0];
        end

        if (state_nxt == DISPLAY) begin
            row_act = 8'd1 << row_idx_nxt;
            for (int c = 0; c < 8; c++) begin
                col_act[c] = (slot_nxt < line_nxt[c]);
            end
        end

        row_out_nxt = row_act ^ ROW_OFF;
        col_out_nxt = col_act ^ COL_OFF;
    end

endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan: RAM model, per-row display scoreboard, directed scan scenarios.
module tb_led_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] row_out;
    logic [7:0] col_out;
    logic [2:0] row_idx;
    logic       frame_done;

    led_scan_if ram ();

    led_scan #(
        .SLOT_CYCLES (2),
        .BLANK_CYCLES(3),
        .ROW_ACT_LOW (0),
        .COL_ACT_LOW (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ram       (ram),
        .row_out   (row_out),
        .col_out   (col_out),
        .row_idx   (row_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // RAM model: one-clk read latency; illegal addresses return a marker nibble
    logic [3:0] mem [64];
    int ram_r, ram_c;

    function automatic int oh_idx(input logic [7:0] v);
        int idx = -1;
        int n   = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i;
                n++;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    always @(posedge clk) begin
        ram_r = oh_idx(ram.rd_row);
        ram_c = oh_idx(ram.rd_col);
        if (ram_r >= 0 && ram_c >= 0) ram.rd_data <= mem[ram_r*8 + ram_c];
        else                          ram.rd_data <= 4'hA;
    end

    typedef struct packed {
        logic [7:0]  row;
        logic [39:0] lit;
    } exp_t;

    exp_t exp_q[$];

    // Expected column on-time is 2 clks per brightness step.
    task automatic push_row(input int r);
        exp_t e;
        e.row = 8'd1 << r;
        e.lit = '0;
        for (int c = 0; c < 8; c++) e.lit[c*5 +: 5] = 5'(2 * mem[r*8 + c]);
        exp_q.push_back(e);
    endtask

    task automatic push_hand(input int r, input int l0, input int l1, input int l2, input int l3,
                             input int l4, input int l5, input int l6, input int l7);
        exp_t e;
        int   v [8];
        v = '{l0, l1, l2, l3, l4, l5, l6, l7};
        e.row = 8'd1 << r;
        for (int c = 0; c < 8; c++) e.lit[c*5 +: 5] = 5'(v[c]);
        exp_q.push_back(e);
    endtask

    // Monitor: accumulates one displayed row and compares it when the row goes dark.
    int          mon_len;
    logic [7:0]  mon_row;
    logic [39:0] mon_lit;
    logic        mon_rd_bad;
    logic        mon_col_bad;
    exp_t        mon_e;

    initial begin
        mon_len = 0; mon_row = '0; mon_lit = '0; mon_rd_bad = 1'b0; mon_col_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_len = 0; mon_row = '0; mon_lit = '0; mon_rd_bad = 1'b0; mon_col_bad = 1'b0;
            end else if (row_out != 8'h00) begin
                mon_len++;
                mon_row = row_out;
                for (int c = 0; c < 8; c++)
                    if (!col_out[c]) mon_lit[c*5 +: 5] = mon_lit[c*5 +: 5] + 5'd1;
                if (ram.rd_row != 8'h00 || ram.rd_col != 8'h00) mon_rd_bad = 1'b1;
            end else begin
                if (col_out != 8'hFF) mon_col_bad = 1'b1;
                if (mon_len != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row actual=%0h required=none", mon_row);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("row_sel", mon_row, mon_e.row);
                        check("col_ontime", mon_lit, mon_e.lit);
                        check("row_len", mon_len, 30);
                        check("rd_idle_in_display", mon_rd_bad, 0);
                        check("cols_dark_off_display", mon_col_bad, 0);
                    end
                    mon_len = 0; mon_lit = '0; mon_rd_bad = 1'b0; mon_col_bad = 1'b0;
                end
            end
        end
    end

    task automatic wait_fd(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 2000);
        check(nm, frame_done, 1);
    endtask

    task automatic wait_row(input logic [7:0] v, input string nm);
        int n = 0;
        while (row_out !== v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(nm, row_out, v);
    endtask

    task automatic wait_rd(input logic [7:0] v, input string nm);
        int n = 0;
        while (ram.rd_row !== v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(nm, ram.rd_row, v);
    endtask

    task automatic check_dark(input string nm);
        check({nm, "_row_out"}, row_out, 8'h00);
        check({nm, "_col_out"}, col_out, 8'hFF);
        check({nm, "_rd_row"}, ram.rd_row, 8'h00);
        check({nm, "_rd_col"}, ram.rd_col, 8'h00);
        check({nm, "_row_idx"}, row_idx, 3'd0);
        check({nm, "_frame_done"}, frame_done, 1'b0);
    endtask

    // Counts negedges from now until a row lights up.
    task automatic count_to_light(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (row_out == 8'h00 && n < 200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int t1, t2, n;
        logic [7:0] exp_col;
        int r3 [8];

        rst    = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        repeat (3) @(negedge clk);
        check_dark("reset");
        rst = 1'b0;

        // all-dark RAM: rows walk 01..80, frame_done every 336 clks
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 8; r++) push_row(r);
        enable = 1'b1;
        wait_fd("fd_first");
        t1 = cyc;
        @(negedge clk);
        check("fd_one_clk", frame_done, 0);
        wait_fd("fd_second");
        t2 = cyc;
        check("frame_period", t2 - t1, 336);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("q_empty_dark", exp_q.size(), 0);

        // PWM widths, fetch sequence of row 3, write during row 2 display
        r3 = '{7, 0, 15, 3, 9, 1, 12, 6};
        for (int c = 0; c < 8; c++) begin
            mem[c]      = 4'(c < 6 ? c : c + 8);
            mem[16 + c] = 4'd5;
            mem[24 + c] = 4'(r3[c]);
        end
        push_hand(0, 0, 2, 4, 6, 8, 10, 28, 30);
        for (int r = 1; r < 8; r++) push_row(r);
        enable = 1'b1;
        wait_row(8'h04, "row2_reached");
        for (int c = 0; c < 8; c++) mem[16 + c] = 4'd9;
        for (int r = 0; r < 8; r++) push_row(r);

        wait_rd(8'h08, "row3_fetch_start");
        for (int k = 0; k < 8; k++) begin
            exp_col = 8'd1 << k;
            check("fetch_rd_row", ram.rd_row, 8'h08);
            check("fetch_rd_col", ram.rd_col, exp_col);
            check("fetch_row_idx", row_idx, 3'd3);
            @(negedge clk);
        end
        check("fetch_end_rd_row", ram.rd_row, 8'h00);
        check("fetch_end_rd_col", ram.rd_col, 8'h00);

        wait_fd("fd_frame_a");
        wait_fd("fd_frame_b");
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("q_empty_pwm", exp_q.size(), 0);

        // enable dropped mid-FETCH of row 5
        for (int r = 0; r < 5; r++) push_row(r);
        enable = 1'b1;
        wait_rd(8'h20, "row5_fetch_start");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_dark("drop");
        repeat (4) @(negedge clk);
        enable = 1'b1;
        count_to_light(n);
        check("reenable_latency", n, 13);
        check("reenable_row", row_out, 8'h01);

        // async reset in the middle of row 0 display
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_dark("async_rst");
        repeat (2) @(negedge clk);
        push_row(0);
        push_row(1);
        rst = 1'b0;
        count_to_light(n);
        check("rst_restart_latency", n, 13);
        check("rst_restart_row", row_out, 8'h01);
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("q_drain", exp_q.size(), 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
